// File: rtl/param_sync_fifo.sv
`timescale 1ns/1ps
// Parameterised single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds and sticky overflow/underflow flags.
module param_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              full_flag;
    logic              empty_flag;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] head_word;

    assign full_flag  = (count_q == DEPTH_CNT);
    assign empty_flag = (count_q == '0);
    assign head_word  = mem_q[rd_ptr_q];

    always_comb begin
        wr_accept   = wr_en & ~full_flag;
        rd_accept   = rd_en & ~empty_flag;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q | (wr_en & full_flag);
        underflow_d = underflow_q | (rd_en & empty_flag);

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        // In FWFT mode dout_q keeps the last popped word, shown while empty.
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = head_word;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = ((FWFT != 0) && !empty_flag) ? head_word : dout_q;
    assign full         = full_flag;
    assign empty        = empty_flag;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
`timescale 1ns/1ps
// Directed bench for param_sync_fifo: default registered-read instance, an FWFT
// instance and a small 32-bit/4-deep instance, all on one clock.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // instance a: defaults, FWFT=0
  logic       a_rst, a_wr, a_rd;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0] a_cnt;

  // instance b: FWFT=1
  logic       b_rst, b_wr, b_rd;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0] b_cnt;

  // instance c: 32-bit, 4 deep
  logic        c_rst, c_wr, c_rd;
  logic [31:0] c_din, c_dout;
  logic        c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
  logic [2:0]  c_cnt;

  logic [7:0] exp_q[$];

  param_sync_fifo u_a (
    .clk(clk), .reset(a_rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_udf)
  );

  param_sync_fifo #(.FWFT(1)) u_b (
    .clk(clk), .reset(b_rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_udf)
  );

  param_sync_fifo #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_c (
    .clk(clk), .reset(c_rst), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
    .data_out(c_dout), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .count(c_cnt), .overflow(c_ovf), .underflow(c_udf)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  e8;
    logic [31:0] c_words [4];

    c_words[0] = 32'hA000_0001;
    c_words[1] = 32'hB000_0002;
    c_words[2] = 32'hC000_0003;
    c_words[3] = 32'hD000_0004;

    a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    c_rst = 1'b1; c_wr = 1'b0; c_rd = 1'b0; c_din = '0;
    tick;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // reset state
    check_eq("a_rst_count", a_cnt, 0);
    check_eq("a_rst_empty", a_empty, 1);
    check_eq("a_rst_ae", a_ae, 1);
    check_eq("a_rst_full", a_full, 0);
    check_eq("a_rst_af", a_af, 0);
    check_eq("a_rst_ovf", a_ovf, 0);
    check_eq("a_rst_udf", a_udf, 0);
    check_eq("a_rst_dout", a_dout, 0);
    check_eq("b_rst_dout", b_dout, 0);

    // fill 16 words 0x01..0x10
    for (int i = 0; i < 16; i++) begin
      a_din = 8'(i + 1); a_wr = 1'b1;
      tick;
      check_eq("a_fill_count", a_cnt, 64'(i + 1));
      check_eq("a_fill_af", a_af, ((i + 1) >= 14) ? 64'd1 : 64'd0);
      check_eq("a_fill_full", a_full, ((i + 1) == 16) ? 64'd1 : 64'd0);
    end

    // 17th write while full is dropped
    a_din = 8'hAA; a_wr = 1'b1;
    tick;
    a_wr = 1'b0;
    check_eq("a_ovf_count", a_cnt, 16);
    check_eq("a_ovf_set", a_ovf, 1);
    tick;
    check_eq("a_ovf_sticky", a_ovf, 1);

    // drain 16, data one cycle after the read edge
    for (int i = 0; i < 16; i++) begin
      a_rd = 1'b1;
      tick;
      check_eq("a_drain_dout", a_dout, 64'(i + 1));
      check_eq("a_drain_count", a_cnt, 64'(15 - i));
    end
    check_eq("a_drain_empty", a_empty, 1);

    // read while empty
    a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    check_eq("a_udf_set", a_udf, 1);
    check_eq("a_udf_dout_hold", a_dout, 8'h10);
    check_eq("a_udf_count", a_cnt, 0);

    // count 8, then 40 cycles of simultaneous read/write
    for (int i = 0; i < 8; i++) begin
      a_din = 8'(8'h20 + i); a_wr = 1'b1;
      exp_q.push_back(a_din);
      tick;
    end
    check_eq("a_steady_start", a_cnt, 8);
    for (int i = 0; i < 40; i++) begin
      a_din = 8'(8'h28 + i); a_wr = 1'b1; a_rd = 1'b1;
      exp_q.push_back(a_din);
      tick;
      e8 = exp_q.pop_front();
      check_eq("a_steady_dout", a_dout, e8);
      check_eq("a_steady_count", a_cnt, 8);
    end
    a_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_rd = 1'b1;
      tick;
      e8 = exp_q.pop_front();
      check_eq("a_tail_dout", a_dout, e8);
    end
    a_rd = 1'b0;
    check_eq("a_tail_empty", a_empty, 1);

    // count 10, overflow still set, reset pulse with wr_en high
    for (int i = 0; i < 10; i++) begin
      a_din = 8'(8'h40 + i); a_wr = 1'b1;
      tick;
    end
    check_eq("a_pre_rst_count", a_cnt, 10);
    check_eq("a_pre_rst_ovf", a_ovf, 1);
    a_rst = 1'b1; a_din = 8'h77; a_wr = 1'b1;
    tick;
    a_rst = 1'b0; a_wr = 1'b0;
    check_eq("a_prst_count", a_cnt, 0);
    check_eq("a_prst_empty", a_empty, 1);
    check_eq("a_prst_ovf", a_ovf, 0);
    check_eq("a_prst_udf", a_udf, 0);
    check_eq("a_prst_dout", a_dout, 0);

    // write and read together while empty: only the write lands
    a_din = 8'h99; a_wr = 1'b1; a_rd = 1'b1;
    tick;
    a_wr = 1'b0;
    check_eq("a_wr_rd_empty_count", a_cnt, 1);
    check_eq("a_wr_rd_empty_udf", a_udf, 1);
    check_eq("a_wr_rd_empty_dout", a_dout, 0);
    tick;
    a_rd = 1'b0;
    check_eq("a_post_rst_dout", a_dout, 8'h99);
    check_eq("a_post_rst_empty", a_empty, 1);

    // FWFT instance
    b_din = 8'h5A; b_wr = 1'b1;
    tick;
    b_wr = 1'b0;
    check_eq("b_fwft_dout", b_dout, 8'h5A);
    check_eq("b_fwft_empty", b_empty, 0);
    b_rd = 1'b1;
    tick;
    b_rd = 1'b0;
    check_eq("b_pop_empty", b_empty, 1);
    check_eq("b_pop_hold", b_dout, 8'h5A);
    b_din = 8'h11; b_wr = 1'b1;
    tick;
    b_din = 8'h22;
    tick;
    b_wr = 1'b0;
    check_eq("b_head0", b_dout, 8'h11);
    b_rd = 1'b1;
    tick;
    check_eq("b_head1", b_dout, 8'h22);
    tick;
    b_rd = 1'b0;
    check_eq("b_last_hold", b_dout, 8'h22);
    check_eq("b_last_empty", b_empty, 1);

    // small instance thresholds at counts 0..4
    check_eq("c_ae_0", c_ae, 1);
    check_eq("c_af_0", c_af, 0);
    for (int i = 0; i < 4; i++) begin
      c_din = c_words[i]; c_wr = 1'b1;
      tick;
      check_eq("c_count", c_cnt, 64'(i + 1));
      check_eq("c_ae", c_ae, (i == 0) ? 64'd1 : 64'd0);
      check_eq("c_af", c_af, (i >= 2) ? 64'd1 : 64'd0);
    end
    check_eq("c_full", c_full, 1);

    // write and read together while full: only the read lands
    c_din = 32'hDEAD_BEEF; c_wr = 1'b1; c_rd = 1'b1;
    tick;
    c_wr = 1'b0;
    check_eq("c_wr_rd_full_count", c_cnt, 3);
    check_eq("c_wr_rd_full_ovf", c_ovf, 1);
    check_eq("c_wr_rd_full_dout", c_dout, 32'hA000_0001);
    for (int i = 1; i < 4; i++) begin
      tick;
      check_eq("c_drain_dout", c_dout, c_words[i]);
    end
    c_rd = 1'b0;
    check_eq("c_drain_empty", c_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage words (power of two, >=4).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 Parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request (FWFT=1: pop/acknowledge of head word).
REQ-011 data_out  output  DATA_W  read data.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_LEVEL.
REQ-015 almost_empty  output  1  count <= AE_LEVEL.
REQ-016 count  output  clog2(DEPTH)+1  words currently stored, 0..DEPTH.
REQ-017 overflow  output  1  sticky: write attempted while full.
REQ-018 underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 Write accepted iff wr_en=1 and full=0 at the edge; word stored at wr_ptr, wr_ptr increments.
REQ-020 Read accepted iff rd_en=1 and empty=0 at the edge; rd_ptr increments.
REQ-021 Pointers are clog2(DEPTH) bits and wrap DEPTH-1 -> 0 with no gap or lost word.
REQ-022 count: +1 write only, -1 read only, unchanged when both or neither accepted.
REQ-023 Simultaneous wr_en and rd_en when full: only read accepted, count DEPTH -> DEPTH-1, write data dropped, overflow set.
REQ-024 Simultaneous wr_en and rd_en when empty: only write accepted, count 0 -> 1, underflow set.
REQ-025 All flags derive from registered count only; no combinational path from wr_en/rd_en/data_in to any output.
REQ-026 FWFT=0: data_out registered, loaded with head word on the edge of an accepted read (1-cycle latency), else holds.
REQ-027 FWFT=1: data_out equals head word whenever empty=0; a written word is visible the cycle after the write edge; accepted read advances to next word; data_out holds last value when empty=1.
REQ-028 overflow set on edge where wr_en=1 and full=1; underflow set on edge where rd_en=1 and empty=1; both remain 1 until reset.
REQ-029 Rejected accesses do not change pointers, count, memory or data_out.
REQ-030 Storage is an array of DEPTH x DATA_W words; storage contents are not reset.

Reset
REQ-031 reset=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-032 reset has priority over wr_en/rd_en in the same cycle; in-flight reads/writes are discarded, no partial update.
REQ-033 First access accepted on the first edge with reset=0.

Verification
REQ-034 Defaults, FWFT=0: write 0x01..0x10 (16 words) -> full=1 after 16th edge, count=16, almost_full from count 14; read 16 -> data_out 0x01..0x10 in order, each 1 cycle after rd edge, empty=1 at end.
REQ-035 Write 17th word 0xAA while full -> dropped, overflow=1 and stays 1; rd_en while empty -> underflow=1, data_out unchanged.
REQ-036 Count=8, wr_en=rd_en=1 for 40 cycles with incrementing data -> count stays 8, pointers wrap twice, output sequence exact.
REQ-037 FWFT=1: write 0x5A into empty FIFO -> data_out=0x5A next cycle with rd_en=0; rd_en=1 -> empty=1, data_out holds 0x5A.
REQ-038 count=10, overflow=1, reset pulsed one cycle with wr_en=1 -> count=0, empty=1, overflow=0, data_out=0; next write stored at address 0.
REQ-039 DATA_W=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1: fill 0->4 -> almost_empty 1,1,0,0,0 and almost_full 0,0,0,1,1 at counts 0..4.
